// File: rtl/dram_bank_model_if.sv
// Command/response bundle between a DRAM bank model and its requester.
// The requester drives commands through the master modport.
interface dram_bank_model_if #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8
);
  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd;
  logic [BANK_W-1:0]       bank_id;
  logic [ROW_W-1:0]        rowid;
  logic [COL_W-1:0]        colid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rdata_valid;
  logic                    err;
  logic [NUM_OF_BANKS-1:0] bank_open;

  modport master (
    output cmd_valid, cmd, bank_id, rowid, colid, wdata,
    input  cmd_ready, rdata, rdata_valid, err, bank_open
  );

  modport slave (
    input  cmd_valid, cmd, bank_id, rowid, colid, wdata,
    output cmd_ready, rdata, rdata_valid, err, bank_open
  );
endinterface

// File: rtl/dram_bank_model.sv
// Cycle-accurate multi-bank DRAM model: per-bank IDLE/ACTIVATING/ACTIVE/PRECHARGING
// state machine, row buffer with write-back on precharge, and a CL-deep read pipeline.
module dram_bank_model #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int T_RCD        = 2,
  parameter int CL           = 2,
  parameter int T_RP         = 2
) (
  input logic              clk,
  input logic              rst,
  dram_bank_model_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int MAX_T  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;

  // Timers count down to zero in the transient state; a delay of 1 skips it entirely.
  localparam logic [CNT_W-1:0] RCD_LOAD = (T_RCD > 1) ? CNT_W'(T_RCD - 2) : '0;
  localparam logic [CNT_W-1:0] RP_LOAD  = (T_RP > 1) ? CNT_W'(T_RP - 2) : '0;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_state_e;

  bank_state_e             state_r    [NUM_OF_BANKS];
  logic [CNT_W-1:0]        cnt_r      [NUM_OF_BANKS];
  logic [ROW_W-1:0]        open_row_r [NUM_OF_BANKS];
  logic [DATA_WIDTH-1:0]   rowbuf_r   [NUM_OF_BANKS][NUM_OF_COLS];
  logic [DATA_WIDTH-1:0]   mem_r      [NUM_OF_BANKS][NUM_OF_ROWS][NUM_OF_COLS] = '{default: '0};
  logic [CL-1:0]           vpipe_r;
  logic [DATA_WIDTH-1:0]   dpipe_r    [CL];
  logic                    err_r;

  logic [NUM_OF_BANKS-1:0] busy_s;
  logic [NUM_OF_BANKS-1:0] active_s;
  logic [NUM_OF_BANKS-1:0] pc_s;
  logic                    ready_s;
  logic                    acc_s;
  logic                    tgt_active_s;
  logic                    act_ok_s;
  logic                    rd_ok_s;
  logic                    wr_ok_s;
  logic                    pre_ok_s;
  logic                    prea_ok_s;
  logic                    illegal_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;

  // Per-bank status flags decoded from the registered state.
  always_comb begin
    busy_s   = '0;
    active_s = '0;
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      busy_s[b]   = (state_r[b] == ST_ACTIVATING) || (state_r[b] == ST_PRECHARGING);
      active_s[b] = (state_r[b] == ST_ACTIVE);
    end
  end

  // Flow control and command classification.
  always_comb begin
    tgt_active_s = active_s[bus.bank_id];
    rd_word_s    = rowbuf_r[bus.bank_id][bus.colid];
    if (rst) begin
      ready_s = 1'b0;
    end else if (bus.cmd == CMD_NOP) begin
      ready_s = 1'b1;
    end else if (bus.cmd == CMD_PREA) begin
      ready_s = ~|busy_s;
    end else begin
      ready_s = ~busy_s[bus.bank_id];
    end
    acc_s     = bus.cmd_valid & ready_s;
    act_ok_s  = 1'b0;
    rd_ok_s   = 1'b0;
    wr_ok_s   = 1'b0;
    pre_ok_s  = 1'b0;
    prea_ok_s = 1'b0;
    illegal_s = 1'b0;
    if (acc_s) begin
      // An accepted command never targets a busy bank, so "not active" means IDLE.
      case (bus.cmd)
        CMD_NOP:  illegal_s = 1'b0;
        CMD_ACT:  begin illegal_s = tgt_active_s;  act_ok_s = ~tgt_active_s; end
        CMD_RD:   begin illegal_s = ~tgt_active_s; rd_ok_s  = tgt_active_s;  end
        CMD_WR:   begin illegal_s = ~tgt_active_s; wr_ok_s  = tgt_active_s;  end
        CMD_PRE:  pre_ok_s  = tgt_active_s;
        CMD_PREA: prea_ok_s = 1'b1;
        default:  illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      pc_s[b] = active_s[b] & (prea_ok_s | (pre_ok_s & (bus.bank_id == BANK_W'(b))));
    end
  end

  // Bank state machines, timers and row buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        state_r[b]    <= ST_IDLE;
        cnt_r[b]      <= '0;
        open_row_r[b] <= '0;
        rowbuf_r[b]   <= '{default: '0};
      end
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        case (state_r[b])
          ST_IDLE: begin
            if (act_ok_s && (bus.bank_id == BANK_W'(b))) begin
              open_row_r[b] <= bus.rowid;
              rowbuf_r[b]   <= mem_r[b][bus.rowid];
              state_r[b]    <= (T_RCD == 1) ? ST_ACTIVE : ST_ACTIVATING;
              cnt_r[b]      <= RCD_LOAD;
            end
          end
          ST_ACTIVATING: begin
            if (cnt_r[b] == '0) begin
              state_r[b] <= ST_ACTIVE;
            end else begin
              cnt_r[b] <= cnt_r[b] - 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (pc_s[b]) begin
              state_r[b] <= (T_RP == 1) ? ST_IDLE : ST_PRECHARGING;
              cnt_r[b]   <= RP_LOAD;
            end else if (wr_ok_s && (bus.bank_id == BANK_W'(b))) begin
              rowbuf_r[b][bus.colid] <= bus.wdata;
            end
          end
          ST_PRECHARGING: begin
            if (cnt_r[b] == '0) begin
              state_r[b] <= ST_IDLE;
            end else begin
              cnt_r[b] <= cnt_r[b] - 1'b1;
            end
          end
          default: state_r[b] <= ST_IDLE;
        endcase
      end
    end
  end

  // Row write-back on precharge; array contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
      if (!rst && pc_s[b]) begin
        mem_r[b][open_row_r[b]] <= rowbuf_r[b];
      end
    end
  end

  // Read latency pipeline and error pulse; data stages stay zero when not carrying a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_r <= '0;
      err_r   <= 1'b0;
      for (int i = 0; i < CL; i++) begin
        dpipe_r[i] <= '0;
      end
    end else begin
      vpipe_r[0] <= rd_ok_s;
      dpipe_r[0] <= rd_ok_s ? rd_word_s : '0;
      for (int i = 1; i < CL; i++) begin
        vpipe_r[i] <= vpipe_r[i-1];
        dpipe_r[i] <= dpipe_r[i-1];
      end
      err_r <= illegal_s;
    end
  end

  assign bus.cmd_ready   = ready_s;
  assign bus.rdata       = rst ? '0 : dpipe_r[CL-1];
  assign bus.rdata_valid = ~rst & vpipe_r[CL-1];
  assign bus.err         = ~rst & err_r;
  assign bus.bank_open   = rst ? '0 : active_s;
endmodule

// File: tb/tb_dram_bank_model.sv
// Self-checking bench for dram_bank_model: table of command vectors plus
// hand-written sequences, with a cycle-stamped scoreboard for rdata and err.
module tb_dram_bank_model;
  localparam int NB = 8, NR = 128, NC = 8, DW = 8;
  localparam int T_RCD = 2, CL = 2, T_RP = 2;
  localparam int BW = $clog2(NB), RW = $clog2(NR), CW = $clog2(NC);

  localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4, CMD_PREA = 3'd5, CMD_BAD6 = 3'd6, CMD_BAD7 = 3'd7;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;

  dram_bank_model_if #(.NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW)) bus ();

  dram_bank_model #(
    .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
    .T_RCD(T_RCD), .CL(CL), .T_RP(T_RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    logic [2:0]    c;
    int            b;
    int            r;
    int            col;
    logic [DW-1:0] wd;
    bit            is_rd;
    logic [DW-1:0] exp;
    bit            exp_err;
  } vec_t;

  rd_exp_t rd_q[$];
  int      err_q[$];
  vec_t    vecs[17];
  rd_exp_t mon_e;
  bit      mon_exp_v;
  bit      mon_exp_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard: every cycle, compare rdata/rdata_valid and err against stamped expectations.
  always @(posedge clk) begin
    #1;
    if (mon_on) begin
      mon_exp_v = (rd_q.size() != 0) && (rd_q[0].cyc == cyc);
      check("rdata_valid", bus.rdata_valid, mon_exp_v);
      if (mon_exp_v) begin
        mon_e = rd_q.pop_front();
        check("rdata", bus.rdata, mon_e.data);
      end else begin
        check("rdata_idle_zero", bus.rdata, 0);
        if ((rd_q.size() != 0) && (rd_q[0].cyc < cyc)) mon_e = rd_q.pop_front();
      end
      mon_exp_e = (err_q.size() != 0) && (err_q[0] == cyc);
      check("err", bus.err, mon_exp_e);
      if (mon_exp_e || ((err_q.size() != 0) && (err_q[0] < cyc))) void'(err_q.pop_front());
    end
  end

  task automatic idle();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
  endtask

  task automatic drive(input logic [2:0] c, input int b, input int r, input int col, input logic [DW-1:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.bank_id   = b[BW-1:0];
    bus.rowid     = r[RW-1:0];
    bus.colid     = col[CW-1:0];
    bus.wdata     = wd;
  endtask

  // Present a command from the next falling edge and hold it until accepted (bounded).
  task automatic issue(input logic [2:0] c, input int b, input int r, input int col,
                       input logic [DW-1:0] wd, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    drive(c, b, r, col, wd);
    #1;
    while (!bus.cmd_ready && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!bus.cmd_ready) check("accept_timeout", bus.cmd_ready, 1'b1);
    acc = cyc;
    @(posedge clk);
  endtask

  task automatic send(input logic [2:0] c, input int b, input int r, input int col,
                      input logic [DW-1:0] wd, input bit is_rd, input logic [DW-1:0] exp,
                      input bit exp_err, output int acc);
    issue(c, b, r, col, wd, acc);
    if (is_rd) rd_q.push_back(rd_exp_t'{acc + CL, exp});
    if (exp_err) err_q.push_back(acc + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd       = CMD_NOP;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_rdata_valid", bus.rdata_valid, 1'b0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", bus.err, 1'b0);
    check("rst_bank_open", bus.bank_open, 0);
    repeat (2) @(negedge clk);
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    int a1;
    int p;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = CMD_NOP;
    bus.bank_id   = '0;
    bus.rowid     = '0;
    bus.colid     = '0;
    bus.wdata     = '0;

    // {cmd, bank, row, col, wdata, is_rd, expected rdata, expected err}
    vecs[0]  = '{CMD_ACT,  2, 5, 0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{CMD_WR,   2, 0, 3, 8'hA5, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{CMD_RD,   2, 0, 3, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{CMD_RD,   4, 0, 0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{CMD_ACT,  2, 9, 0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{CMD_RD,   2, 0, 3, 8'h00, 1'b1, 8'hA5, 1'b0};
    vecs[6]  = '{CMD_WR,   2, 0, 0, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{CMD_WR,   2, 0, 1, 8'h02, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{CMD_WR,   2, 0, 2, 8'h03, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{CMD_WR,   2, 0, 3, 8'h04, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{CMD_RD,   2, 0, 0, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[11] = '{CMD_RD,   2, 0, 1, 8'h00, 1'b1, 8'h02, 1'b0};
    vecs[12] = '{CMD_RD,   2, 0, 2, 8'h00, 1'b1, 8'h03, 1'b0};
    vecs[13] = '{CMD_RD,   2, 0, 3, 8'h00, 1'b1, 8'h04, 1'b0};
    vecs[14] = '{CMD_BAD6, 0, 0, 0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[15] = '{CMD_BAD7, 1, 0, 0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[16] = '{CMD_PRE,  4, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0};

    // Power-up reset: outputs must be quiet even before the first edge.
    @(negedge clk);
    #1;
    check("por_cmd_ready", bus.cmd_ready, 1'b0);
    check("por_bank_open", bus.bank_open, 0);
    check("por_rdata_valid", bus.rdata_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;

    for (int i = 0; i < 17; i++) begin
      send(vecs[i].c, vecs[i].b, vecs[i].r, vecs[i].col, vecs[i].wd,
           vecs[i].is_rd, vecs[i].exp, vecs[i].exp_err, a0);
    end
    idle();
    repeat (4) @(negedge clk);

    // RD right behind ACT on the same bank stalls T_RCD-1 cycles.
    send(CMD_ACT, 0, 1, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    @(negedge clk);
    drive(CMD_RD, 0, 0, 0, 8'h00);
    #1;
    check("stall_ready_low", bus.cmd_ready, 1'b0);
    send(CMD_RD, 0, 0, 0, 8'h00, 1'b1, 8'h00, 1'b0, a1);
    check("stall_accept_cycle", a1, a0 + T_RCD);

    // Another bank is accepted while bank 0 is still activating.
    send(CMD_PRE, 0, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, p);
    send(CMD_ACT, 0, 1, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    check("act_after_pre_cycle", a0, p + T_RP);
    send(CMD_ACT, 3, 2, 0, 8'h00, 1'b0, 8'h00, 1'b0, a1);
    check("act_other_bank_no_stall", a1, a0 + 1);
    idle();
    repeat (T_RCD) @(negedge clk);
    #1;
    check("bank_open_b0_b2_b3", bus.bank_open, 8'h0D);
    send(CMD_PREA, 0, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, p);
    idle();
    repeat (T_RP + 1) @(negedge clk);

    // Write-back on PRE survives a reopen; an unclosed row is lost across reset.
    send(CMD_ACT, 1, 7, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_WR,  1, 0, 0, 8'h3C, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_PRE, 1, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_ACT, 1, 7, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_RD,  1, 0, 0, 8'h00, 1'b1, 8'h3C, 1'b0, a0);
    send(CMD_PRE, 1, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_ACT, 1, 8, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_WR,  1, 0, 0, 8'h3C, 1'b0, 8'h00, 1'b0, a0);
    idle();
    repeat (4) @(negedge clk);
    do_reset();
    send(CMD_ACT, 1, 8, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_RD,  1, 0, 0, 8'h00, 1'b1, 8'h00, 1'b0, a0);
    send(CMD_PRE, 1, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_ACT, 1, 7, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_RD,  1, 0, 0, 8'h00, 1'b1, 8'h3C, 1'b0, a0);
    send(CMD_PREA, 0, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    idle();
    repeat (T_RP + 2) @(negedge clk);

    // PREA closes banks 0 and 5; contents persist on reopen.
    send(CMD_ACT, 0, 3, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_WR,  0, 0, 2, 8'h11, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_ACT, 5, 4, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_WR,  5, 0, 6, 8'h22, 1'b0, 8'h00, 1'b0, a0);
    idle();
    #1;
    check("bank_open_b0_b5", bus.bank_open, 8'h21);
    send(CMD_PREA, 0, 0, 0, 8'h00, 1'b0, 8'h00, 1'b0, p);
    @(negedge clk);
    drive(CMD_ACT, 0, 3, 0, 8'h00);
    #1;
    check("prea_busy_ready_low", bus.cmd_ready, 1'b0);
    check("prea_bank_open", bus.bank_open, 0);
    send(CMD_ACT, 0, 3, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    check("reopen_after_prea_cycle", a0, p + T_RP);
    send(CMD_RD,  0, 0, 2, 8'h00, 1'b1, 8'h11, 1'b0, a0);
    send(CMD_ACT, 5, 4, 0, 8'h00, 1'b0, 8'h00, 1'b0, a0);
    send(CMD_RD,  5, 0, 6, 8'h00, 1'b1, 8'h22, 1'b0, a0);
    idle();
    repeat (4) @(negedge clk);

    // Reset while a read is in flight: nothing may emerge.
    issue(CMD_RD, 5, 0, 6, 8'h00, a0);
    do_reset();
    idle();
    repeat (8) @(negedge clk);

    check("rd_queue_drained", rd_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
